ddrio_align_seq: RTL and testbench

- Bring-up and re-alignment sequencer that drives the control inputs of the x2 DDR I/O pair: `cken`, `align_ol` and `align_il`.
- Runs in the fast output-clock domain. After reset release it enables clocks, lets the gearboxes settle, then issues ordered output-side and input-side align pulses.
- Reports completion to the PHY controller. Re-runs the sequence on a toggle request from the slow (gsclk) domain.

---
 rtl/ddrio_align_pkg.sv | 35 +++
 rtl/ddrio_tgl_sync.sv | 25 ++
 rtl/ddrio_align_seq.sv | 125 ++++++++++++
 tb/tb_ddrio_align_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ddrio_align_pkg.sv
// Shared definitions for the x2 DDR I/O alignment sequencer: state encoding,
// default cycle counts and the phase-counter width helper.
package ddrio_align_pkg;

  localparam int unsigned WaitCycDef   = 16;
  localparam int unsigned SettleCycDef = 8;
  localparam int unsigned PulseCycDef  = 2;
  localparam int unsigned GapCycDef    = 4;
  localparam int unsigned PostCycDef   = 4;
  localparam int unsigned CntWDef      = 8;

  typedef enum logic [2:0] {
    StWait    = 3'd0,
    StSettle  = 3'd1,
    StAlignOl = 3'd2,
    StGap     = 3'd3,
    StAlignIl = 3'd4,
    StPost    = 3'd5,
    StDone    = 3'd6
  } align_st_e;

  // One bit of headroom above the largest phase length.
  function automatic int unsigned phase_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d,
                                              input int unsigned e);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/ddrio_tgl_sync.sv
// Level-toggle request crossing: two synchronizer flops, a history flop, and a
// single-cycle event on every edge of the synchronized level.
module ddrio_tgl_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tgl_i,
  output logic evt_o
);

  logic [1:0] sync_q;
  logic       hist_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 2'b00;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], tgl_i};
      hist_q <= sync_q[1];
    end
  end

  assign evt_o = sync_q[1] ^ hist_q;

endmodule

// File: rtl/ddrio_align_seq.sv
// Bring-up / re-alignment sequencer for the x2 DDR I/O pair: clock enable,
// ordered output- then input-gearbox align pulses, completion and a run counter.
module ddrio_align_seq
  import ddrio_align_pkg::*;
#(
  parameter int unsigned WAIT_CYC   = WaitCycDef,
  parameter int unsigned SETTLE_CYC = SettleCycDef,
  parameter int unsigned PULSE_CYC  = PulseCycDef,
  parameter int unsigned GAP_CYC    = GapCycDef,
  parameter int unsigned POST_CYC   = PostCycDef,
  parameter int unsigned CNT_W      = CntWDef
) (
  input  logic             geclk_ol_buf_o,
  input  logic             align_rst_ol,
  input  logic             realign_tgl,
  output logic             cken,
  output logic             align_ol,
  output logic             align_il,
  output logic             align_done,
  output logic             busy,
  output logic [CNT_W-1:0] align_cnt
);

  localparam int unsigned PhW = phase_width(WAIT_CYC, SETTLE_CYC, PULSE_CYC, GAP_CYC, POST_CYC);

  if (WAIT_CYC == 0 || SETTLE_CYC == 0 || PULSE_CYC == 0 || GAP_CYC == 0 || POST_CYC == 0 ||
      CNT_W == 0) begin : gen_bad_param
    $error("ddrio_align_seq: all *_CYC parameters and CNT_W must be >= 1");
  end

  align_st_e        state_q, state_d;
  logic [PhW-1:0]   phase_q, phase_d;
  logic [PhW-1:0]   last_ph;
  logic             pend_q, pend_d;
  logic             evt;

  logic             cken_q, align_ol_q, align_il_q, align_done_q, busy_q;
  logic [CNT_W-1:0] align_cnt_q;

  ddrio_tgl_sync u_tgl_sync (
    .clk_i (geclk_ol_buf_o),
    .rst_i (align_rst_ol),
    .tgl_i (realign_tgl),
    .evt_o (evt)
  );

  always_comb begin
    last_ph = '0;
    unique case (state_q)
      StWait:              last_ph = PhW'(WAIT_CYC - 1);
      StSettle:            last_ph = PhW'(SETTLE_CYC - 1);
      StAlignOl, StAlignIl: last_ph = PhW'(PULSE_CYC - 1);
      StGap:               last_ph = PhW'(GAP_CYC - 1);
      StPost:              last_ph = PhW'(POST_CYC - 1);
      default:             last_ph = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    unique case (state_q)
      StWait:    if (phase_q == last_ph) state_d = StSettle;
      StSettle:  if (phase_q == last_ph) state_d = StAlignOl;
      StAlignOl: if (phase_q == last_ph) state_d = StGap;
      StGap:     if (phase_q == last_ph) state_d = StAlignIl;
      StAlignIl: if (phase_q == last_ph) state_d = StPost;
      StPost:    if (phase_q == last_ph) state_d = StDone;
      StDone: begin
        if (evt || pend_q) begin
          state_d = StWait;
          pend_d  = 1'b0;
        end
      end
      default:   state_d = StWait;
    endcase
    // Requests outside DONE are remembered and served once DONE is reached.
    if (evt && state_q != StDone) pend_d = 1'b1;

    if (state_d != state_q)    phase_d = '0;
    else if (state_q == StDone) phase_d = phase_q;
    else                        phase_d = phase_q + 1'b1;
  end

  always_ff @(posedge geclk_ol_buf_o or posedge align_rst_ol) begin
    if (align_rst_ol) begin
      state_q <= StWait;
      phase_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pend_q  <= pend_d;
    end
  end

  // Outputs are a registered decode of the current state, one cycle behind it.
  always_ff @(posedge geclk_ol_buf_o or posedge align_rst_ol) begin
    if (align_rst_ol) begin
      cken_q       <= 1'b0;
      align_ol_q   <= 1'b0;
      align_il_q   <= 1'b0;
      align_done_q <= 1'b0;
      busy_q       <= 1'b1;
      align_cnt_q  <= '0;
    end else begin
      cken_q       <= (state_q != StWait);
      align_ol_q   <= (state_q == StAlignOl);
      align_il_q   <= (state_q == StAlignIl);
      align_done_q <= (state_q == StDone);
      busy_q       <= (state_q != StDone);
      if (state_q == StDone && !align_done_q && align_cnt_q != '1) begin
        align_cnt_q <= align_cnt_q + 1'b1;
      end
    end
  end

  assign cken       = cken_q;
  assign align_ol   = align_ol_q;
  assign align_il   = align_il_q;
  assign align_done = align_done_q;
  assign busy       = busy_q;
  assign align_cnt  = align_cnt_q;

endmodule

// File: tb/tb_ddrio_align_seq.sv
// Bench for ddrio_align_seq: three instances (default, all-ones timing, 2-bit counter)
// checked every cycle against a timeline model of the alignment sequence.
module tb_ddrio_align_seq;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] rst = '0;
  logic [NI-1:0] tgl = '0;
  logic [NI-1:0] cken, aol, ail, done, busy;
  logic [7:0]    cnt0, cnt1;
  logic [1:0]    cnt2;

  ddrio_align_seq u_dut_def (
    .geclk_ol_buf_o (clk),
    .align_rst_ol   (rst[0]),
    .realign_tgl    (tgl[0]),
    .cken           (cken[0]),
    .align_ol       (aol[0]),
    .align_il       (ail[0]),
    .align_done     (done[0]),
    .busy           (busy[0]),
    .align_cnt      (cnt0)
  );

  ddrio_align_seq #(
    .WAIT_CYC   (1),
    .SETTLE_CYC (1),
    .PULSE_CYC  (1),
    .GAP_CYC    (1),
    .POST_CYC   (1)
  ) u_dut_min (
    .geclk_ol_buf_o (clk),
    .align_rst_ol   (rst[1]),
    .realign_tgl    (tgl[1]),
    .cken           (cken[1]),
    .align_ol       (aol[1]),
    .align_il       (ail[1]),
    .align_done     (done[1]),
    .busy           (busy[1]),
    .align_cnt      (cnt1)
  );

  ddrio_align_seq #(
    .CNT_W (2)
  ) u_dut_sat (
    .geclk_ol_buf_o (clk),
    .align_rst_ol   (rst[2]),
    .realign_tgl    (tgl[2]),
    .cken           (cken[2]),
    .align_ol       (aol[2]),
    .align_il       (ail[2]),
    .align_done     (done[2]),
    .busy           (busy[2]),
    .align_cnt      (cnt2)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] get_cnt(input int i);
    case (i)
      0:       return 32'(cnt0);
      1:       return 32'(cnt1);
      default: return 32'(cnt2);
    endcase
  endfunction

  function automatic logic [4:0] get_outs(input int i);
    return {cken[i], aol[i], ail[i], done[i], busy[i]};
  endfunction

  // Per-instance timing and counter limit
  int p_w[NI]    = '{16, 1, 16};
  int p_s[NI]    = '{8, 1, 8};
  int p_p[NI]    = '{2, 1, 2};
  int p_g[NI]    = '{4, 1, 4};
  int p_q[NI]    = '{4, 1, 4};
  int p_cmax[NI] = '{255, 255, 3};

  // Model: cyc = index of last edge since reset release, base = edge at which the
  // current sequence started (offset 0 = first WAIT cycle).
  int cyc[NI]  = '{-1, -1, -1};
  int base[NI] = '{0, 0, 0};
  int mcnt[NI] = '{0, 0, 0};
  bit pend[NI];
  bit h1[NI], h2[NI], h3[NI];

  task automatic model_step(input int i, input bit r, input bit t);
    int off, tot, n;
    bit ev;
    logic [4:0] exp;
    if (r) begin
      cyc[i] = -1; base[i] = 0; mcnt[i] = 0; pend[i] = 0;
      h1[i] = 0; h2[i] = 0; h3[i] = 0;
      check_val($sformatf("i%0d rst_outs", i), 32'(get_outs(i)), 32'(5'b00001));
      check_val($sformatf("i%0d rst_cnt", i), get_cnt(i), 0);
    end else begin
      cyc[i]++;
      n   = cyc[i];
      off = n - base[i];
      tot = p_w[i] + p_s[i] + 2 * p_p[i] + p_g[i] + p_q[i];
      if (off == tot && mcnt[i] < p_cmax[i]) mcnt[i]++;
      exp = {off >= p_w[i],
             off >= p_w[i] + p_s[i] && off < p_w[i] + p_s[i] + p_p[i],
             off >= p_w[i] + p_s[i] + p_p[i] + p_g[i] &&
               off < p_w[i] + p_s[i] + 2 * p_p[i] + p_g[i],
             off >= tot,
             off < tot};
      check_val($sformatf("i%0d c%0d outs", i, n), 32'(get_outs(i)), 32'(exp));
      check_val($sformatf("i%0d c%0d cnt", i, n), get_cnt(i), 32'(mcnt[i]));
      // Request seen at this edge = toggle level change sampled 2..3 edges ago.
      ev = h2[i] ^ h3[i];
      h3[i] = h2[i]; h2[i] = h1[i]; h1[i] = t;
      if (off >= tot) begin
        if (ev || pend[i]) begin
          base[i] = n + 1;
          pend[i] = 0;
        end
      end else if (ev) begin
        pend[i] = 1;
      end
    end
  endtask

  always @(posedge clk) begin
    logic [NI-1:0] r_s, t_s;
    r_s = rst;
    t_s = tgl;
    #1;
    for (int i = 0; i < NI; i++) model_step(i, r_s[i], t_s[i]);
  end

  task automatic wait_cyc(input int i, input int k);
    int guard;
    guard = 0;
    while (cyc[i] < k && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc[i] < k) check_val($sformatf("i%0d wait_timeout", i), 32'(cyc[i]), 32'(k));
  endtask

  task automatic pulse_rst(input int i);
    @(negedge clk);
    rst[i] = 1'b1;
    @(negedge clk);
    rst[i] = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int i, d, a;
    #1 rst = '1;
    repeat (3) @(negedge clk);
    rst = '0;

    // Default bring-up
    wait_cyc(0, 45);
    check_val("t1_cnt", get_cnt(0), 1);
    check_val("t1_busy", 32'(busy[0]), 0);
    check_val("t5_done", 32'(done[1]), 1);

    // Re-align request while DONE
    wait_cyc(0, 50);
    tgl[0] = ~tgl[0];
    wait_cyc(0, 54);
    check_val("t2_cken_drop", 32'(cken[0]), 0);
    wait_cyc(0, 95);
    check_val("t2_cnt", get_cnt(0), 2);

    // Two requests during SETTLE collapse into one re-run
    pulse_rst(0);
    wait_cyc(0, 20);
    tgl[0] = ~tgl[0];
    wait_cyc(0, 22);
    tgl[0] = ~tgl[0];
    wait_cyc(0, 140);
    check_val("t3_cnt", get_cnt(0), 2);

    // Asynchronous reset while align_ol is high
    pulse_rst(0);
    wait_cyc(0, 25);
    check_val("t4_ol_high", 32'(aol[0]), 1);
    rst[0] = 1'b1;
    #1;
    check_val("t4_async_outs", 32'(get_outs(0)), 32'(5'b00001));
    check_val("t4_async_cnt", get_cnt(0), 0);
    @(negedge clk);
    rst[0] = 1'b0;
    wait_cyc(0, 40);

    // Counter saturation on the 2-bit instance
    for (int r = 0; r < 5; r++) begin
      wait_cyc(2, cyc[2] + 45);
      tgl[2] = ~tgl[2];
    end
    wait_cyc(2, cyc[2] + 45);
    check_val("t6_cnt_sat", get_cnt(2), 3);

    // Randomized requests and resets on all instances
    for (int k = 0; k < 80; k++) begin
      i = int'($urandom_range(0, NI - 1));
      d = int'($urandom_range(1, 60));
      a = int'($urandom_range(0, 9));
      wait_cyc(i, cyc[i] + d);
      if (a == 0) begin
        pulse_rst(i);
      end else if (a < 3) begin
        tgl[i] = ~tgl[i];
        wait_cyc(i, cyc[i] + int'($urandom_range(1, 4)));
        tgl[i] = ~tgl[i];
      end else begin
        tgl[i] = ~tgl[i];
      end
    end
    repeat (60) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
